// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter shared types
// FSM states, grant owners, default timing
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACC,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    GNT_INST,
    GNT_DATA
  } gnt_t;

  localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: inst/data ports share one SRAM
// data port has strict priority; FSM owns strobes
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ce_n,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       inst_data,
  output logic              inst_ready,
  input  logic              data_ce_n,
  input  logic              data_we_n,
  input  logic [3:0]        data_be_n,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ready,
  output logic              stall_from_bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  arb_state_t state;
  gnt_t       gnt;
  logic [3:0] cnt;
  logic       wr_q;
  logic       data_req;
  logic       any_req;
  logic       unused_bits;

  assign data_req = ~data_ce_n;
  assign any_req  = ~data_ce_n | ~inst_ce_n;

  // only word-address bits reach the SRAM
  assign unused_bits = ^{inst_addr[31:ADDR_W+2],
                         inst_addr[1:0],
                         data_addr[31:ADDR_W+2],
                         data_addr[1:0]};

  // held low during reset so stall_ctrl sees a clean start
  assign stall_from_bus = rst &
    ((~inst_ce_n & ~inst_ready) |
     (~data_ce_n & ~data_ready));

  // access sequencer with registered strobes and ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB_IDLE;
      gnt          <= GNT_INST;
      cnt          <= '0;
      wr_q         <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'hF;
      sram_addr    <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      inst_ready   <= 1'b0;
      data_ready   <= 1'b0;
      inst_data    <= '0;
      data_rdata   <= '0;
    end else begin
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            state     <= ARB_ACC;
            cnt       <= '0;
            sram_ce_n <= 1'b0;
            gnt       <= data_req ? GNT_DATA
                                  : GNT_INST;
            wr_q      <= data_req & ~data_we_n;
            sram_addr <= data_req
              ? data_addr[ADDR_W+1:2]
              : inst_addr[ADDR_W+1:2];
            if (data_req && !data_we_n) begin
              sram_we_n    <= 1'b0;
              sram_be_n    <= data_be_n;
              sram_data_o  <= data_wdata;
              sram_data_oe <= 1'b1;
            end else begin
              sram_oe_n <= 1'b0;
              sram_be_n <= 4'h0;
            end
          end
        end
        ARB_ACC: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            state        <= ARB_DONE;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'hF;
            sram_data_oe <= 1'b0;
            if (gnt == GNT_DATA) begin
              data_ready <= 1'b1;
              if (!wr_q) data_rdata <= sram_data_i;
            end else begin
              inst_ready <= 1'b1;
              inst_data  <= sram_data_i;
            end
          end else if (wr_q) begin
            sram_we_n <= (cnt + 4'd1 == LAST);
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Shares a single external word-wide SRAM between the instruction-fetch port (icache miss path) and the data port (mem_ctrl).
- Sequences each access with a multi-cycle FSM that owns the SRAM control strobes.
- Returns read data to the requester with a one-cycle ready pulse.
- Drives stall_from_bus into stall_ctrl while any request is unserved.
- Sits between the CPU core and the top-level SRAM tristate pads.

Parameters:
ADDR_W, 20, SRAM word-address width; sram_addr = byte address[ADDR_W+1:2]
WAIT_CYCLES, 2, SRAM access cycles minus one; legal range 1..15

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is asynchronous and active-low
inst_ce_n  input  1  instruction request, active-low, held until inst_ready
inst_addr  input  32  instruction byte address
inst_data  output  32  fetched word, valid while inst_ready=1
inst_ready  output  1  one-cycle completion pulse for instruction access
data_ce_n  input  1  data request, active-low, held until data_ready
data_we_n  input  1  0=write, 1=read
data_be_n  input  4  write byte enables, active-low
data_addr  input  32  data byte address
data_wdata  input  32  store data
data_rdata  output  32  load word, valid while data_ready=1
data_ready  output  1  one-cycle completion pulse for data access
stall_from_bus  output  1  to stall_ctrl: a request is pending and not yet completed
sram_addr  output  ADDR_W  SRAM word address
sram_data_o  output  32  SRAM write data
sram_data_oe  output  1  top-level tristate enable for sram_data_o
sram_data_i  input  32  SRAM read data
sram_ce_n  output  1  SRAM chip enable
sram_oe_n  output  1  SRAM output enable
sram_we_n  output  1  SRAM write enable
sram_be_n  output  4  SRAM byte enables

Behaviour:
- Reset (rst=0, asynchronous) sets registers to:
  - state=IDLE, cnt=0
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF
  - sram_addr=0, sram_data_o=0, sram_data_oe=0
  - inst_ready=0, data_ready=0, inst_data=0, data_rdata=0
  - stall_from_bus forced 0 while rst=0.
- All SRAM-side outputs are registered. Ready and read-data outputs are registered.
- stall_from_bus is combinational: (~inst_ce_n & ~inst_ready) | (~data_ce_n & ~data_ready).
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - If data_ce_n=0, grant data. Otherwise, if inst_ce_n=0, grant inst.
  - Data has strict priority (MEM stage is older). No starvation is possible because the pipeline stalls as a whole.
  - On grant: latch addr, we, be_n and wdata; go to ACC with cnt=0.
- ACC:
  - sram_ce_n=0 and sram_addr=granted word address for all ACC cycles.
  - Read: sram_oe_n=0, sram_be_n=4'h0, sram_data_oe=0.
  - Write: sram_data_oe=1, sram_data_o=wdata, sram_be_n=data_be_n. sram_we_n=0 while cnt<WAIT_CYCLES, then 1 at cnt=WAIT_CYCLES (data hold cycle).
  - cnt increments each cycle.
  - At cnt=WAIT_CYCLES:
    - Read: capture sram_data_i into inst_data or data_rdata.
    - Go to DONE.
- DONE:
  - All strobes deasserted, sram_data_oe=0 (bus turnaround).
  - The granted port's ready=1 for exactly this cycle.
  - Return to IDLE; the next request is sampled there.
- Latency: request seen in IDLE at cycle 0; ACC occupies cycles 1..WAIT_CYCLES+1; ready at cycle WAIT_CYCLES+2. Back-to-back accesses are WAIT_CYCLES+3 cycles apart.
- A write returns data_ready; data_rdata is left unchanged.
- Request withdrawn mid-access: the access completes and ready still pulses. Write strobes are never truncated.
- Both requests present in IDLE: data is served first, inst in the following IDLE. stall_from_bus stays 1 throughout.
- Reset mid-access: all strobes are released immediately and no ready is issued.
- inst_ready and data_ready are never 1 in the same cycle.
- Address bits [1:0] and bits above ADDR_W+1 are ignored.

Decomposition:
- Shared package/defines holds:
  - state encodings (ARB_IDLE, ARB_ACC, ARB_DONE)
  - grant encodings (GNT_INST, GNT_DATA)
  - default WAIT_CYCLES
- Single flat module; no sub-module is natural.

Test Plan:
1. Inst read, WAIT_CYCLES=2: inst_ce_n=0, addr=0x80000010, SRAM word 4 = 0x12345678 -> sram_addr=4, oe_n low cycles 1-3, inst_ready=1 and inst_data=0x12345678 at cycle 4; stall_from_bus=1 for cycles 0-3.
2. Data byte write: data_we_n=0, be_n=4'b1110, addr=0x80000008, wdata=0xDEADBEEF -> sram_addr=2, we_n low cycles 1-2, high cycle 3 with data still driven; data_ready at cycle 4; only byte 0 changes to 0xEF.
3. Simultaneous inst (0x0) and data read (0x100, word 0xCAFEBABE) -> data_ready at cycle 4 with 0xCAFEBABE; inst_ready at cycle 9; never both high.
4. Reset asserted at cycle 2 of a write -> strobes high and sram_data_oe=0 immediately; no ready; after release the FSM sits in IDLE.
5. data_ce_n released at cycle 2 of a read -> access still runs to completion, data_ready pulses at cycle 4, FSM back in IDLE at cycle 5.
6. WAIT_CYCLES=1, back-to-back inst reads 0x0 and 0x4 -> inst_ready at cycles 3 and 7.
